// File: rtl/hazard_unit.sv
// ID-stage pipeline hazard controller: load-use and branch/JALR operand stalls,
// IF flush on taken control transfers, and saturating stall/flush event counters.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_Branch,
  input  logic             id_jump,
  input  logic             id_jalr,
  input  logic             id_branch_taken,
  input  logic             ex_MemRead,
  input  logic             ex_Regwrite,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_MemRead,
  input  logic [REG_W-1:0] mem_rd,
  output logic             hz_bubble,
  output logic             hz_PC_write,
  output logic             hz_IFID_write,
  output logic             hz_IF_flush,
  output logic [CNT_W-1:0] hz_stall_cnt,
  output logic [CNT_W-1:0] hz_flush_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic             rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       exm, memm, ctl;
  logic [1:0] need;
  logic       stall, flush;

  // x0 is hardwired zero, so a write to it can never feed a consumer
  always_comb begin
    exm  = (ex_rd != '0) &&
           ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    memm = (mem_rd != '0) &&
           ((id_use_rs1 && (mem_rd == id_rs1)) || (id_use_rs2 && (mem_rd == id_rs2)));
    ctl  = id_Branch || id_jalr;

    need = 2'd0;
    if (ctl && ex_MemRead && exm)
      need = 2'd2;
    else if ((ex_MemRead && exm) || (ctl && ex_Regwrite && exm) || (ctl && mem_MemRead && memm))
      need = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (need != 2'd0) begin
          stall = 1'b1;
          if (need == 2'd2) begin
            state_d = HOLD;
            rem_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        stall   = 1'b1;
        if (rem_q)
          rem_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = 1'b0;
      end
    endcase
    if (rst)
      stall = 1'b0;
  end

  // Stall takes priority: a branch outcome seen while stalled is not trustworthy
  always_comb begin
    flush         = !rst && !stall && (id_jump || (id_Branch && id_branch_taken));
    hz_bubble     = stall;
    hz_PC_write   = !stall;
    hz_IFID_write = !stall;
    hz_IF_flush   = flush;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz_stall_cnt = stall_cnt_q;
  assign hz_flush_cnt = flush_cnt_q;

endmodule
